// File: rtl/notch_gain_monitor_if.sv
// -----------------------------------------------------------------------------
// notch_gain_monitor_if
//   Bundles the control, sample-stream and result signals of notch_gain_monitor.
//   Clock and reset stay plain ports on the module.
//
//   Signals:
//     start            one-cycle measurement request (master -> slave)
//     busy             monitor is in MEASURE or HOLD (slave -> master)
//     s_valid/s_ready  sample-pair handshake; s_in/s_out are signed DW-bit
//     m_valid/m_ready  result handshake
//     in_peak/out_peak unsigned peak magnitudes of the last window
//     notch            output attenuated below 2^ATTEN_SHIFT of input
//
//   Modports:
//     master  stimulus / consumer side
//     slave   the monitor itself
// -----------------------------------------------------------------------------
interface notch_gain_monitor_if #(
  parameter int DW = 12
);
  logic                 start;
  logic                 busy;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_in;
  logic signed [DW-1:0] s_out;
  logic                 m_valid;
  logic                 m_ready;
  logic        [DW-1:0] in_peak;
  logic        [DW-1:0] out_peak;
  logic                 notch;

  modport master (
    output start, s_valid, s_in, s_out, m_ready,
    input  busy, s_ready, m_valid, in_peak, out_peak, notch
  );

  modport slave (
    input  start, s_valid, s_in, s_out, m_ready,
    output busy, s_ready, m_valid, in_peak, out_peak, notch
  );
endinterface

// File: rtl/notch_gain_monitor.sv
// -----------------------------------------------------------------------------
// notch_gain_monitor
//   Captures the peak magnitude of paired filter-input / filter-output samples
//   over a window of 2^WIN_LOG2 accepted pairs, then reports both peaks and a
//   notch flag set when (out_peak << ATTEN_SHIFT) < in_peak.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    notch_gain_monitor_if.slave (start/busy, s_* sample stream,
//            m_* result handshake, in_peak, out_peak, notch)
//
//   Parameters:
//     DW           sample width (signed two's complement)
//     WIN_LOG2     window length is 2^WIN_LOG2 accepted pairs
//     ATTEN_SHIFT  notch threshold is a factor of 2^ATTEN_SHIFT
//
//   Build option:
//     NOTCH_MON_AUTORESTART_EN  when defined, taking a result in HOLD starts
//                               the next window immediately instead of
//                               returning to IDLE.
// -----------------------------------------------------------------------------
module notch_gain_monitor #(
  parameter int DW          = 12,
  parameter int WIN_LOG2    = 8,
  parameter int ATTEN_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  notch_gain_monitor_if.slave  bus
);

  // Channel 0 is the filter input, channel 1 the filter output.
  localparam int CH = 2;
  localparam int CW = DW + ATTEN_SHIFT;
  localparam logic [WIN_LOG2:0] CNT_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIN_LOG2:0]      cnt_q, cnt_d;
  logic [CH-1:0][DW-1:0]  samp;
  logic [CH-1:0][DW-1:0]  mag;
  logic [CH-1:0][DW-1:0]  peak_max;
  logic [CH-1:0][DW-1:0]  peak_q, peak_d;
  logic [CH-1:0][DW-1:0]  res_q, res_d;
  logic                   notch_q, notch_d;
  logic                   accept;
  logic                   last_pair;
  logic                   result_taken;
  logic                   enter_measure;
  logic [CW-1:0]          in_wide;
  logic [CW-1:0]          out_scaled;

  assign samp[0] = bus.s_in;
  assign samp[1] = bus.s_out;

  // Magnitude in DW-bit unsigned arithmetic: the most negative code negates
  // to 2^(DW-1), which is representable unsigned, so no saturation is needed.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign mag[gi]      = samp[gi][DW-1] ? (~samp[gi] + DW'(1)) : samp[gi];
      assign peak_max[gi] = (mag[gi] > peak_q[gi]) ? mag[gi] : peak_q[gi];
    end
  endgenerate

  assign accept       = bus.s_valid && (state_q == ST_MEASURE);
  assign last_pair    = accept && (cnt_q == CNT_LAST);
  assign result_taken = (state_q == ST_HOLD) && bus.m_ready;
  assign enter_measure = (state_d == ST_MEASURE) && (state_q != ST_MEASURE);

  // Threshold compare at DW+ATTEN_SHIFT bits uses the peaks including the
  // final pair, so the flag is valid on the first HOLD cycle.
  assign in_wide    = CW'(peak_max[0]);
  assign out_scaled = CW'(peak_max[1]) << ATTEN_SHIFT;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_MEASURE;
      ST_MEASURE: if (last_pair) state_d = ST_HOLD;
      ST_HOLD: begin
        if (result_taken) begin
`ifdef NOTCH_MON_AUTORESTART_EN
          state_d = ST_MEASURE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.busy     = (state_q != ST_IDLE);
    bus.s_ready  = (state_q == ST_MEASURE);
    bus.m_valid  = (state_q == ST_HOLD);
    bus.in_peak  = res_q[0];
    bus.out_peak = res_q[1];
    bus.notch    = notch_q;
  end

  // ---------------------------------------------------------------- datapath
  // Working peaks track the window; result registers only change when a
  // window completes, so the reported values stay stable through HOLD.
  always_comb begin
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    res_d   = res_q;
    notch_d = notch_q;
    if (enter_measure) begin
      cnt_d  = '0;
      peak_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      peak_d = peak_max;
    end
    if (last_pair) begin
      res_d   = peak_max;
      notch_d = (out_scaled < in_wide);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      peak_q  <= '0;
      res_q   <= '0;
      notch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      res_q   <= res_d;
      notch_q <= notch_d;
    end
  end

endmodule
